// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability filter and press/release strobes.
// Optional auto-repeat while held is enabled by defining HOLD_REPEAT_EN.
// Without that macro there is no hold timer, and button_repeat is tied low.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = 16,
  parameter bit          ACTIVE_LOW    = 1'b0,
  parameter logic [23:0] REPEAT_DELAY  = 24'd12_000_000,
  parameter logic [23:0] REPEAT_PERIOD = 24'd3_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic button_state,
  output logic button_down,
  output logic button_up,
  output logic button_repeat
);

`ifdef HOLD_REPEAT_EN
  typedef enum logic [1:0] {StReleased, StPressed, StRepeat} state_e;
`else
  typedef enum logic [0:0] {StReleased, StPressed} state_e;
`endif

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             p;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic             down_q, down_d;
  logic             up_q, up_d;
  logic             rel_accept;

  // Pressed level after synchronisation and polarity normalisation.
  assign p = s2_q ^ ACTIVE_LOW;

  // Synchroniser chain; reset loads the released pad level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= ACTIVE_LOW;
      s2_q <= ACTIVE_LOW;
    end else begin
      s1_q <= button;
      s2_q <= s1_q;
    end
  end

`ifdef HOLD_REPEAT_EN
  logic [23:0] timer_q, timer_d;
  logic        rep_q, rep_d;

  // Hold timer and repeat strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      rep_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      rep_q   <= rep_d;
    end
  end

  assign button_repeat = rep_q;
`else
  // Repeat configuration is only meaningful with the hold timer present.
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign button_repeat     = 1'b0;
`endif

  // Filter counter, FSM state and press/release strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= StReleased;
      down_q  <= 1'b0;
      up_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      down_q  <= down_d;
      up_q    <= up_d;
    end
  end

  // Stability filter and state transitions; release acceptance outranks the hold timer.
  always_comb begin
    cnt_d      = cnt_q;
    state_d    = state_q;
    down_d     = 1'b0;
    up_d       = 1'b0;
    rel_accept = 1'b0;
`ifdef HOLD_REPEAT_EN
    timer_d    = timer_q;
    rep_d      = 1'b0;
`endif

    if (p == (state_q != StReleased)) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
      if (p) begin
        state_d = StPressed;
        down_d  = 1'b1;
`ifdef HOLD_REPEAT_EN
        timer_d = '0;
`endif
      end else begin
        state_d    = StReleased;
        up_d       = 1'b1;
        rel_accept = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

`ifdef HOLD_REPEAT_EN
    if (!rel_accept) begin
      case (state_q)
        StPressed: begin
          if (timer_q == REPEAT_DELAY - 24'd1) begin
            rep_d   = 1'b1;
            timer_d = '0;
            state_d = StRepeat;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        StRepeat: begin
          if (timer_q == REPEAT_PERIOD - 24'd1) begin
            rep_d   = 1'b1;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
        default: ;
      endcase
    end
`endif
  end

  assign button_state = (state_q != StReleased);
  assign button_down  = down_q;
  assign button_up    = up_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with an event scoreboard.
// Expected pulses (kind + cycle) are queued when stimulus is applied and
// matched against DUT pulses observed 1 time unit after each rising edge.
module tb_button_debouncer;

  localparam int unsigned SC = 4;
  localparam int          LAT = SC + 2;
  localparam logic [2:0]  KDown = 3'b001;
  localparam logic [2:0]  KUp   = 3'b010;
  localparam logic [2:0]  KRep  = 3'b100;

  logic clk = 1'b0;
  logic rst;
  logic button;
  logic button_state;
  logic button_down;
  logic button_up;
  logic button_repeat;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } ev_t;

  ev_t sb[$];
  int  cyc        = 0;
  int  compared   = 0;
  int  mismatched = 0;
  bit  mon_en     = 1'b0;

  always #5 clk = ~clk;

  button_debouncer #(
    .STABLE_CYCLES(SC),
    .CNT_W        (3),
    .ACTIVE_LOW   (1'b0),
    .REPEAT_DELAY (24'd10),
    .REPEAT_PERIOD(24'd5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .button_state (button_state),
    .button_down  (button_down),
    .button_up    (button_up),
    .button_repeat(button_repeat)
  );

  task automatic expect_ev(input int c, input logic [2:0] k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one edge, then match any pulse (or any due expectation) against the scoreboard.
  task automatic tick();
    ev_t        e;
    logic [2:0] obs;
    @(posedge clk);
    #1;
    cyc++;
    obs = {button_repeat, button_up, button_down};
    if (mon_en && (obs !== 3'b000 || (sb.size() > 0 && sb[0].cyc == cyc))) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {29'd0, obs}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_cycle", cyc, e.cyc);
        check("pulse_kind", {29'd0, obs}, {29'd0, e.kind});
      end
    end
  endtask

  initial begin
    int d;
    logic bounce [4];
    bounce[0] = 1'b1;
    bounce[1] = 1'b0;
    bounce[2] = 1'b1;
    bounce[3] = 1'b0;

    // Reset for 3 cycles with button released.
    rst    = 1'b1;
    button = 1'b0;
    repeat (3) tick();
    check("rst_state", {31'd0, button_state}, 32'd0);
    check("rst_down", {31'd0, button_down}, 32'd0);
    check("rst_up", {31'd0, button_up}, 32'd0);
    check("rst_repeat", {31'd0, button_repeat}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (10) tick();
    check("idle_state", {31'd0, button_state}, 32'd0);

    // Clean press and release.
    button = 1'b1;
    expect_ev(cyc + LAT, KDown);
    repeat (LAT - 1) tick();
    check("press_state_early", {31'd0, button_state}, 32'd0);
    tick();
    check("press_state", {31'd0, button_state}, 32'd1);
    repeat (4) tick();
    button = 1'b0;
    expect_ev(cyc + LAT, KUp);
    repeat (LAT - 1) tick();
    check("release_state_early", {31'd0, button_state}, 32'd1);
    tick();
    check("release_state", {31'd0, button_state}, 32'd0);
    repeat (4) tick();

    // Bounce 1,0,1,0 then held high: one press, timed from the final rise.
    for (int i = 0; i < 4; i++) begin
      button = bounce[i];
      tick();
    end
    button = 1'b1;
    expect_ev(cyc + LAT, KDown);
    repeat (LAT) tick();
    check("bounce_state", {31'd0, button_state}, 32'd1);
    button = 1'b0;
    expect_ev(cyc + LAT, KUp);
    repeat (10) tick();
    check("bounce_release_state", {31'd0, button_state}, 32'd0);

    // 3-cycle glitch must be filtered completely.
    button = 1'b1;
    repeat (3) tick();
    check("glitch_state_mid", {31'd0, button_state}, 32'd0);
    button = 1'b0;
    repeat (10) tick();
    check("glitch_state", {31'd0, button_state}, 32'd0);
    check("glitch_no_events", sb.size(), 32'd0);

    // Reset while held: no release pulse, fresh press after reset.
    button = 1'b1;
    expect_ev(cyc + LAT, KDown);
    repeat (8) tick();
    check("pre_rst_state", {31'd0, button_state}, 32'd1);
    rst = 1'b1;
    tick();
    check("mid_rst_state", {31'd0, button_state}, 32'd0);
    rst = 1'b0;
    expect_ev(cyc + LAT, KDown);
    repeat (LAT - 1) tick();
    check("post_rst_state_early", {31'd0, button_state}, 32'd0);
    tick();
    check("post_rst_state", {31'd0, button_state}, 32'd1);
    button = 1'b0;
    expect_ev(cyc + LAT, KUp);
    repeat (10) tick();

`ifdef HOLD_REPEAT_EN
    // Held press: repeats at +10 then every 5 cycles, none after release.
    button = 1'b1;
    d = cyc + LAT;
    expect_ev(d, KDown);
    for (int k = 10; k <= 30; k += 5) expect_ev(d + k, KRep);
    repeat (LAT + 25) tick();
    button = 1'b0;
    expect_ev(d + 25 + LAT, KUp);
    repeat (20) tick();
    check("repeat_release_state", {31'd0, button_state}, 32'd0);

    // Release accepted on the cycle the first repeat would fire: release wins.
    button = 1'b1;
    d = cyc + LAT;
    expect_ev(d, KDown);
    repeat (LAT + 4) tick();
    button = 1'b0;
    expect_ev(d + 10, KUp);
    repeat (15) tick();
`else
    d = 0;
    // Long hold: button_repeat must stay low.
    button = 1'b1;
    expect_ev(cyc + LAT, KDown);
    repeat (40) tick();
    check("hold_repeat_low", {31'd0, button_repeat}, 32'd0);
    button = 1'b0;
    expect_ev(cyc + LAT, KUp);
    repeat (10) tick();
`endif

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
